// File: rtl/sysbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sysbus_arbiter
// Description : Shares one Sysbus master port between instruction fetch (F)
//               and the data-memory stage (M). A whole line transaction
//               (request phase plus LINE_BEATS response or write-data beats)
//               is granted at a time, with round-robin between the two ports.
// Revision    : 1.0 - initial release
// ============================================================================
module sysbus_arbiter #(
  parameter int TAG_W      = 13,
  parameter int LINE_BEATS = 8,
  parameter int BEAT_W     = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Fetch port
  input  logic              f_reqcyc,
  input  logic [63:0]       f_req,
  input  logic [TAG_W-1:0]  f_reqtag,
  output logic              f_reqack,
  output logic              f_respcyc,
  output logic [63:0]       f_resp,
  // Memory-stage port
  input  logic              m_reqcyc,
  input  logic [63:0]       m_req,
  input  logic [TAG_W-1:0]  m_reqtag,
  output logic              m_reqack,
  output logic              m_respcyc,
  output logic [63:0]       m_resp,
  // Sysbus master side
  output logic              bus_reqcyc,
  output logic [63:0]       bus_req,
  output logic [TAG_W-1:0]  bus_reqtag,
  input  logic              bus_reqack,
  input  logic              bus_respcyc,
  input  logic [63:0]       bus_resp,
  output logic              bus_respack
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_WDATA = 2'd3;

  localparam logic OWN_F = 1'b0;
  localparam logic OWN_M = 1'b1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              dir_q, dir_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              bus_reqcyc_q, bus_reqcyc_d;
  logic [63:0]       bus_req_q, bus_req_d;
  logic [TAG_W-1:0]  bus_reqtag_q, bus_reqtag_d;

  logic              win_m;
  logic              own_reqcyc;
  logic [63:0]       own_req;

  // Next-state logic: arbitration in IDLE, then walk one transaction to completion
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    dir_d        = dir_q;
    beat_d       = beat_q;
    bus_reqcyc_d = bus_reqcyc_q;
    bus_req_d    = bus_req_q;
    bus_reqtag_d = bus_reqtag_q;

    // M wins when alone, or on a tie when F had the previous grant
    win_m      = m_reqcyc & (~f_reqcyc | (last_grant_q == OWN_F));
    own_reqcyc = (owner_q == OWN_M) ? m_reqcyc : f_reqcyc;
    own_req    = (owner_q == OWN_M) ? m_req    : f_req;

    case (state_q)
      ST_IDLE: begin
        if (f_reqcyc | m_reqcyc) begin
          owner_d      = win_m;
          last_grant_d = win_m;
          dir_d        = win_m ? m_reqtag[TAG_W-1] : f_reqtag[TAG_W-1];
          bus_reqcyc_d = 1'b1;
          bus_req_d    = win_m ? m_req    : f_req;
          bus_reqtag_d = win_m ? m_reqtag : f_reqtag;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        // The latched request is completed even if the owner drops reqcyc
        if (bus_reqack) begin
          bus_reqcyc_d = 1'b0;
          state_d      = dir_q ? ST_RESP : ST_WDATA;
        end
      end
      ST_RESP: begin
        if (bus_respcyc) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_WDATA: begin
        // A beat is held stable on the bus until acked; the slot is then
        // emptied for one cycle so the owner, which advances on its own
        // reqack, presents the next beat before it is captured again.
        if (bus_reqcyc_q) begin
          if (bus_reqack) begin
            bus_reqcyc_d = 1'b0;
            if (beat_q == LAST_BEAT) begin
              beat_d  = '0;
              state_d = ST_IDLE;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end else begin
          bus_reqcyc_d = own_reqcyc;
          bus_req_d    = own_req;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and bus-side registers; reset clears everything with no drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_F;
      last_grant_q <= OWN_M;
      dir_q        <= 1'b0;
      beat_q       <= '0;
      bus_reqcyc_q <= 1'b0;
      bus_req_q    <= '0;
      bus_reqtag_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      dir_q        <= dir_d;
      beat_q       <= beat_d;
      bus_reqcyc_q <= bus_reqcyc_d;
      bus_req_q    <= bus_req_d;
      bus_reqtag_q <= bus_reqtag_d;
    end
  end

  // Flag response beats arriving while no read is in progress
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(bus_respcyc && (state_q != ST_RESP)))
        else $warning("sysbus_arbiter: bus_respcyc outside RESP dropped");
    end
  end

  assign bus_reqcyc  = bus_reqcyc_q;
  assign bus_req     = bus_req_q;
  assign bus_reqtag  = bus_reqtag_q;
  assign bus_respack = bus_respcyc;

  // Only the current owner sees acks and response beats
  assign f_reqack  = bus_reqack & (owner_q == OWN_F) &
                     ((state_q == ST_REQ) | (state_q == ST_WDATA));
  assign m_reqack  = bus_reqack & (owner_q == OWN_M) &
                     ((state_q == ST_REQ) | (state_q == ST_WDATA));
  assign f_respcyc = bus_respcyc & (owner_q == OWN_F) & (state_q == ST_RESP);
  assign m_respcyc = bus_respcyc & (owner_q == OWN_M) & (state_q == ST_RESP);
  assign f_resp    = bus_resp;
  assign m_resp    = bus_resp;

endmodule
`default_nettype wire

// File: tb/tb_sysbus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sysbus_arbiter
// Description : Directed self-checking bench for sysbus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sysbus_arbiter;
  localparam int TAG_W      = 13;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              f_reqcyc, m_reqcyc;
  logic [63:0]       f_req, m_req;
  logic [TAG_W-1:0]  f_reqtag, m_reqtag;
  logic              f_reqack, m_reqack, f_respcyc, m_respcyc;
  logic [63:0]       f_resp, m_resp;
  logic              bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]       bus_req, bus_resp;
  logic [TAG_W-1:0]  bus_reqtag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sysbus_arbiter #(.TAG_W(TAG_W), .LINE_BEATS(LINE_BEATS), .BEAT_W(BEAT_W)) dut (
    .clk(clk), .reset(reset),
    .f_reqcyc(f_reqcyc), .f_req(f_req), .f_reqtag(f_reqtag),
    .f_reqack(f_reqack), .f_respcyc(f_respcyc), .f_resp(f_resp),
    .m_reqcyc(m_reqcyc), .m_req(m_req), .m_reqtag(m_reqtag),
    .m_reqack(m_reqack), .m_respcyc(m_respcyc), .m_resp(m_resp),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
    .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
    .bus_respack(bus_respack)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Acts as the Sysbus slave for one read: waits for the request, acks it,
  // then returns LINE_BEATS beats. Reports what the requesters observed.
  task automatic serve_read(input bit drop, output logic [63:0] addr,
                            output int f_beats, output int m_beats,
                            output int stray, output bit m_got_ack);
    int waited = 0;
    addr = '0; f_beats = 0; m_beats = 0; stray = 0; m_got_ack = 1'b0;
    while (!bus_reqcyc && waited < 10) begin
      tick();
      waited++;
    end
    if (!bus_reqcyc) return;
    addr = bus_req;
    bus_reqack = 1'b1;
    #1;
    m_got_ack = m_reqack;
    if (drop && f_reqack) f_reqcyc = 1'b0;
    if (drop && m_reqack) m_reqcyc = 1'b0;
    tick();
    bus_reqack = 1'b0;
    for (int i = 0; i < LINE_BEATS; i++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hA0 + 64'(i);
      #1;
      if (f_respcyc) f_beats++;
      if (m_respcyc) m_beats++;
      if (f_reqack || m_reqack) stray++;
      if (f_resp !== 64'hA0 + 64'(i)) stray++;
      tick();
    end
    bus_respcyc = 1'b0;
    bus_resp    = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL reset_reqcyc: got %b want 0", bus_reqcyc); end
    checks++;
    if (bus_req !== 64'h0) begin errors++; $display("FAIL reset_req: got %h want 0", bus_req); end
    checks++;
    if (bus_reqtag !== 13'h0) begin errors++; $display("FAIL reset_reqtag: got %h want 0", bus_reqtag); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_f_read();
    logic [63:0] a; int fb, mb, st; bit mack;
    fb = 0; mb = 0;
    f_reqcyc = 1'b1; f_req = 64'h1000; f_reqtag = 13'h1005;
    #1;
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL f_read_pre: got %b want 0", bus_reqcyc); end
    tick();
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h1000, 13'h1005}) begin
      errors++; $display("FAIL f_read_grant: got cyc=%b req=%h tag=%h want 1/1000/1005", bus_reqcyc, bus_req, bus_reqtag);
    end
    tick();
    checks++;
    if ({bus_reqcyc, f_reqack} !== 2'b10) begin errors++; $display("FAIL f_read_hold: got cyc,ack=%b want 10", {bus_reqcyc, f_reqack}); end
    tick();
    bus_reqack = 1'b1;
    #1;
    checks++;
    if ({f_reqack, m_reqack} !== 2'b10) begin errors++; $display("FAIL f_read_ack: got f,m=%b want 10", {f_reqack, m_reqack}); end
    f_reqcyc = 1'b0;
    tick();
    bus_reqack = 1'b0;
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL f_read_cyc_clear: got %b want 0", bus_reqcyc); end
    for (int i = 0; i < LINE_BEATS; i++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hB0 + 64'(i);
      #1;
      if (f_respcyc) fb++;
      if (m_respcyc) mb++;
      tick();
    end
    bus_respcyc = 1'b0;
    checks++;
    if ({fb, mb} !== {32'd8, 32'd0}) begin errors++; $display("FAIL f_read_beats: got f=%0d m=%0d want 8/0", fb, mb); end
    // Back in IDLE: a new request is granted with one cycle latency
    f_reqcyc = 1'b1; f_req = 64'h1040; f_reqtag = 13'h1006;
    tick();
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h1040}) begin errors++; $display("FAIL f_read_regrant: got cyc=%b req=%h want 1/1040", bus_reqcyc, bus_req); end
    serve_read(1'b1, a, fb, mb, st, mack);
    checks++;
    if ({fb, st} !== {32'd8, 32'd0}) begin errors++; $display("FAIL f_read_second: got beats=%0d stray=%0d want 8/0", fb, st); end
  endtask

  task automatic test_tie();
    logic [63:0] a; int fb, mb, st; bit mack;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    f_reqcyc = 1'b1; f_req = 64'h2000; f_reqtag = 13'h1000;
    m_reqcyc = 1'b1; m_req = 64'h3000; m_reqtag = 13'h1001;
    tick();
    serve_read(1'b1, a, fb, mb, st, mack);
    checks++;
    if (a !== 64'h2000) begin errors++; $display("FAIL tie_first: got %h want 2000", a); end
    checks++;
    if ({fb, mb, st, 31'd0, mack} !== {32'd8, 32'd0, 32'd0, 32'd0}) begin
      errors++; $display("FAIL tie_f_only: got f=%0d m=%0d stray=%0d mack=%b want 8/0/0/0", fb, mb, st, mack);
    end
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL tie_no_overlap: got %b want 0", bus_reqcyc); end
    tick();
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h3000}) begin errors++; $display("FAIL tie_m_grant: got cyc=%b req=%h want 1/3000", bus_reqcyc, bus_req); end
    serve_read(1'b1, a, fb, mb, st, mack);
    checks++;
    if ({fb, mb} !== {32'd0, 32'd8}) begin errors++; $display("FAIL tie_m_beats: got f=%0d m=%0d want 0/8", fb, mb); end
  endtask

  task automatic test_round_robin();
    logic [63:0] a; int fb, mb, st; bit mack;
    logic [63:0] exp_a [4];
    int bad = 0;
    exp_a[0] = 64'h4000; exp_a[1] = 64'h5000; exp_a[2] = 64'h4000; exp_a[3] = 64'h5000;
    f_reqcyc = 1'b1; f_req = 64'h4000; f_reqtag = 13'h1002;
    m_reqcyc = 1'b1; m_req = 64'h5000; m_reqtag = 13'h1003;
    for (int t = 0; t < 4; t++) begin
      serve_read(1'b0, a, fb, mb, st, mack);
      if (a !== exp_a[t]) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL rr_order: got %0d out-of-order grants want 0", bad); end
    // Requests withdrawn in IDLE before the next edge must be ignored
    f_reqcyc = 1'b0; m_reqcyc = 1'b0;
    tick();
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL rr_dropped_ignored: got %b want 0", bus_reqcyc); end
  endtask

  task automatic test_write();
    logic [63:0] exp_d [8];
    logic [63:0] got [$];
    logic [63:0] a; int fb, mb, st; bit mack;
    int k = 0, acks = 0, bad = 0;
    for (int i = 0; i < 8; i++) exp_d[i] = 64'h11 * 64'(i + 1);
    m_reqcyc = 1'b1; m_req = 64'h6000; m_reqtag = 13'h0007;
    tick();
    checks++;
    if ({bus_reqcyc, bus_req, bus_reqtag} !== {1'b1, 64'h6000, 13'h0007}) begin
      errors++; $display("FAIL wr_grant: got cyc=%b req=%h tag=%h want 1/6000/0007", bus_reqcyc, bus_req, bus_reqtag);
    end
    for (int cyc = 0; cyc < 300 && acks < 9; cyc++) begin
      bus_reqack = bus_reqcyc ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (bus_reqcyc && bus_reqack) begin
        if (acks > 0) got.push_back(bus_req);
        acks++;
      end
      if (m_reqack) begin
        k++;
        if (k <= 8) m_req = exp_d[k-1];
        else m_reqcyc = 1'b0;
      end
      tick();
    end
    bus_reqack = 1'b0;
    checks++;
    if (got.size() !== 8) begin errors++; $display("FAIL wr_beat_count: got %0d want 8", got.size()); end
    for (int i = 0; i < got.size() && i < 8; i++) if (got[i] !== exp_d[i]) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL wr_data: got %0d wrong beats want 0", bad); end
    checks++;
    if (bus_reqcyc !== 1'b0) begin errors++; $display("FAIL wr_end_cyc: got %b want 0", bus_reqcyc); end
    f_reqcyc = 1'b1; f_req = 64'h9000; f_reqtag = 13'h1008;
    tick();
    checks++;
    if ({bus_reqcyc, bus_req} !== {1'b1, 64'h9000}) begin errors++; $display("FAIL wr_idle_regrant: got cyc=%b req=%h want 1/9000", bus_reqcyc, bus_req); end
    serve_read(1'b1, a, fb, mb, st, mack);
  endtask

  task automatic test_reset_mid();
    logic [63:0] a; int fb, mb, st; bit mack;
    f_reqcyc = 1'b1; f_req = 64'h7000; f_reqtag = 13'h1009;
    tick();
    bus_reqack = 1'b1;
    #1;
    f_reqcyc = 1'b0;
    tick();
    bus_reqack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1'b1; bus_resp = 64'hC0 + 64'(i);
      tick();
    end
    bus_respcyc = 1'b1;
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({bus_reqcyc, f_respcyc, m_respcyc} !== 3'b000) begin
      errors++; $display("FAIL mid_reset_outputs: got cyc,f,m=%b want 000", {bus_reqcyc, f_respcyc, m_respcyc});
    end
    tick();
    bus_respcyc = 1'b0;
    reset = 1'b1;
    tick();
    f_reqcyc = 1'b1; f_req = 64'h8000; f_reqtag = 13'h100A;
    tick();
    serve_read(1'b1, a, fb, mb, st, mack);
    checks++;
    if ({a, fb} !== {64'h8000, 32'd8}) begin errors++; $display("FAIL mid_reset_fresh: got addr=%h beats=%0d want 8000/8", a, fb); end
  endtask

  task automatic test_spurious();
    bus_respcyc = 1'b1; bus_resp = 64'hDEAD;
    #1;
    checks++;
    if ({bus_respack, f_respcyc, m_respcyc} !== 3'b100) begin
      errors++; $display("FAIL spurious_resp: got ack,f,m=%b want 100", {bus_respack, f_respcyc, m_respcyc});
    end
    tick();
    bus_respcyc = 1'b0; bus_resp = '0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    f_reqcyc = 1'b0; f_req = '0; f_reqtag = '0;
    m_reqcyc = 1'b0; m_req = '0; m_reqtag = '0;
    bus_reqack = 1'b0; bus_respcyc = 1'b0; bus_resp = '0;
    test_reset();
    test_f_read();
    test_tie();
    test_round_robin();
    test_write();
    test_reset_mid();
    test_spurious();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
